// File: rtl/mux4_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter_if
// Brief    : Request/grant bundle between the four requesters and the arbiter.
// Revision : 1.0
// ============================================================================
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       wdog_err;

    modport master (output req, ack, input gnt, sel, busy, wdog_err);
    modport slave  (input req, ack, output gnt, sel, busy, wdog_err);
endinterface
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Brief    : Four-way round-robin arbiter driving a one-hot grant and MUX4_1
//            select; optional grant watchdog enabled by macro ARB_WDOG_EN.
// Revision : 1.0
// ============================================================================
module mux4_rr_arbiter #(
    parameter logic [15:0] WDOG_LIMIT = 16'd255,
    parameter int          CNT_W      = 16
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    mux4_rr_arbiter_if.slave     arb_if
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       wdog_err_q, wdog_err_d;

    logic       cur_req;
    logic       wdog_fire;
    logic       rel;
    logic [1:0] arb_ptr;
    logic [1:0] win_idx;
    logic       win_vld;

    assign cur_req = arb_if.req[sel_q];

`ifdef ARB_WDOG_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Fires only while the owner still requests; a dropped request is a plain abort.
    assign wdog_fire = (state_q == ST_BUSY) && !arb_if.ack && cur_req &&
                       (cnt_q == CNT_W'(WDOG_LIMIT));
`else
    logic unused_cfg;

    assign unused_cfg = ^{WDOG_LIMIT, 32'(CNT_W)};
    assign wdog_fire  = 1'b0;
`endif

    assign rel     = (state_q == ST_BUSY) && (arb_if.ack || !cur_req || wdog_fire);
    // On release the old owner drops to lowest priority for the same-cycle search.
    assign arb_ptr = rel ? (sel_q + 2'd1) : ptr_q;

    always_comb begin
        win_vld = 1'b0;
        win_idx = arb_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (arb_if.req[arb_ptr + 2'(i)]) begin
                win_vld = 1'b1;
                win_idx = arb_ptr + 2'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        wdog_err_d = 1'b0;
`ifdef ARB_WDOG_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d = ST_BUSY;
                    gnt_d   = 4'b0001 << win_idx;
                    sel_d   = win_idx;
                    busy_d  = 1'b1;
`ifdef ARB_WDOG_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (rel) begin
                    ptr_d      = arb_ptr;
                    wdog_err_d = wdog_fire;
                    if (win_vld) begin
                        gnt_d  = 4'b0001 << win_idx;
                        sel_d  = win_idx;
`ifdef ARB_WDOG_EN
                        cnt_d  = '0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                    end
                end else begin
`ifdef ARB_WDOG_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 2'd0;
            gnt_q      <= 4'b0000;
            sel_q      <= 2'd0;
            busy_q     <= 1'b0;
            wdog_err_q <= 1'b0;
`ifdef ARB_WDOG_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            wdog_err_q <= wdog_err_d;
`ifdef ARB_WDOG_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign arb_if.gnt      = gnt_q;
    assign arb_if.sel      = sel_q;
    assign arb_if.busy     = busy_q;
    assign arb_if.wdog_err = wdog_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Brief    : Directed self-checking bench; observed word is {gnt, sel, busy, wdog_err}.
// Revision : 1.0
// ============================================================================
module tb_mux4_rr_arbiter;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    mux4_rr_arbiter_if bus_if ();

    mux4_rr_arbiter #(
        .WDOG_LIMIT(16'd4),
        .CNT_W     (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb_if(bus_if)
    );

    logic [7:0] obs;
    assign obs = {bus_if.gnt, bus_if.sel, bus_if.busy, bus_if.wdog_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        bus_if.req = 4'b0000;
        bus_if.ack = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        bus_if.req = 4'b0000;
        bus_if.ack = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== 8'b0000_00_0_0) begin
            n_err++; $display("FAIL reset_async: got %b want %b", obs, 8'b0000_00_0_0);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (obs !== 8'b0000_00_0_0) begin
            n_err++; $display("FAIL reset_idle: got %b want %b", obs, 8'b0000_00_0_0);
        end
    endtask

    task automatic test_single;
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        n_vec++;
        if (obs !== 8'b0000_00_0_0) begin
            n_err++; $display("FAIL idle_ack_ignored: got %b want %b", obs, 8'b0000_00_0_0);
        end
        bus_if.req = 4'b0100;
        tick();
        n_vec++;
        if (obs !== 8'b0100_10_1_0) begin
            n_err++; $display("FAIL single_grant: got %b want %b", obs, 8'b0100_10_1_0);
        end
        bus_if.ack = 1'b1;
        bus_if.req = 4'b0000;
        tick();
        bus_if.ack = 1'b0;
        n_vec++;
        if (obs !== 8'b0000_10_0_0) begin
            n_err++; $display("FAIL single_release_sel_hold: got %b want %b", obs, 8'b0000_10_0_0);
        end
        tick();
        n_vec++;
        if (obs !== 8'b0000_10_0_0) begin
            n_err++; $display("FAIL single_idle_stable: got %b want %b", obs, 8'b0000_10_0_0);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp;
        do_reset();
        bus_if.req = 4'b1111;
        tick();
        n_vec++;
        if (obs !== 8'b0001_00_1_0) begin
            n_err++; $display("FAIL b2b_first: got %b want %b", obs, 8'b0001_00_1_0);
        end
        for (int k = 0; k < 4; k++) begin
            exp = {4'b0001 << k, 2'(k), 1'b1, 1'b0};
            tick();
            n_vec++;
            if (obs !== exp) begin
                n_err++; $display("FAIL b2b_hold[%0d]: got %b want %b", k, obs, exp);
            end
            bus_if.ack = 1'b1;
            tick();
            bus_if.ack = 1'b0;
            exp = {4'b0001 << ((k + 1) % 4), 2'((k + 1) % 4), 1'b1, 1'b0};
            n_vec++;
            if (obs !== exp) begin
                n_err++; $display("FAIL b2b_next[%0d]: got %b want %b", k, obs, exp);
            end
        end
        bus_if.req = 4'b0000;
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        n_vec++;
        if (obs !== 8'b0000_00_0_0) begin
            n_err++; $display("FAIL b2b_drain: got %b want %b", obs, 8'b0000_00_0_0);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        bus_if.req = 4'b0010;
        tick();
        n_vec++;
        if (obs !== 8'b0010_01_1_0) begin
            n_err++; $display("FAIL wrap_first: got %b want %b", obs, 8'b0010_01_1_0);
        end
        bus_if.req = 4'b0011;
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        n_vec++;
        if (obs !== 8'b0001_00_1_0) begin
            n_err++; $display("FAIL wrap_ptr2: got %b want %b", obs, 8'b0001_00_1_0);
        end
        bus_if.req = 4'b0000;
        tick();
        n_vec++;
        if (obs !== 8'b0000_00_0_0) begin
            n_err++; $display("FAIL wrap_abort_idle: got %b want %b", obs, 8'b0000_00_0_0);
        end
    endtask

    task automatic test_abort;
        do_reset();
        bus_if.req = 4'b1000;
        tick();
        n_vec++;
        if (obs !== 8'b1000_11_1_0) begin
            n_err++; $display("FAIL abort_grant3: got %b want %b", obs, 8'b1000_11_1_0);
        end
        bus_if.req = 4'b0101;
        tick();
        n_vec++;
        if (obs !== 8'b0001_00_1_0) begin
            n_err++; $display("FAIL abort_regrant: got %b want %b", obs, 8'b0001_00_1_0);
        end
        bus_if.req = 4'b0101;
        tick();
        n_vec++;
        if (obs !== 8'b0001_00_1_0) begin
            n_err++; $display("FAIL abort_other_req_no_disturb: got %b want %b", obs, 8'b0001_00_1_0);
        end
        bus_if.req = 4'b0000;
        tick();
        n_vec++;
        if (obs !== 8'b0000_00_0_0) begin
            n_err++; $display("FAIL abort_idle: got %b want %b", obs, 8'b0000_00_0_0);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus_if.req = 4'b0110;
        tick();
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        n_vec++;
        if (obs !== 8'b0100_10_1_0) begin
            n_err++; $display("FAIL rstmid_setup2: got %b want %b", obs, 8'b0100_10_1_0);
        end
        bus_if.req = 4'b0010;
        tick();
        n_vec++;
        if (obs !== 8'b0010_01_1_0) begin
            n_err++; $display("FAIL rstmid_setup1: got %b want %b", obs, 8'b0010_01_1_0);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== 8'b0000_00_0_0) begin
            n_err++; $display("FAIL rstmid_async_clear: got %b want %b", obs, 8'b0000_00_0_0);
        end
        bus_if.req = 4'b1001;
        tick();
        n_vec++;
        if (obs !== 8'b0000_00_0_0) begin
            n_err++; $display("FAIL rstmid_held: got %b want %b", obs, 8'b0000_00_0_0);
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (obs !== 8'b0001_00_1_0) begin
            n_err++; $display("FAIL rstmid_ptr0: got %b want %b", obs, 8'b0001_00_1_0);
        end
        bus_if.req = 4'b0000;
        tick();
    endtask

    task automatic test_watchdog;
        do_reset();
        bus_if.req = 4'b0011;
        tick();
        n_vec++;
        if (obs !== 8'b0001_00_1_0) begin
            n_err++; $display("FAIL wdog_grant: got %b want %b", obs, 8'b0001_00_1_0);
        end
`ifdef ARB_WDOG_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (obs !== 8'b0001_00_1_0) begin
                n_err++; $display("FAIL wdog_hold[%0d]: got %b want %b", i, obs, 8'b0001_00_1_0);
            end
        end
        tick();
        n_vec++;
        if (obs !== 8'b0010_01_1_1) begin
            n_err++; $display("FAIL wdog_fire: got %b want %b", obs, 8'b0010_01_1_1);
        end
        tick();
        n_vec++;
        if (obs !== 8'b0010_01_1_0) begin
            n_err++; $display("FAIL wdog_pulse_end: got %b want %b", obs, 8'b0010_01_1_0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (obs !== 8'b0010_01_1_0) begin
                n_err++; $display("FAIL wdog_hold2[%0d]: got %b want %b", i, obs, 8'b0010_01_1_0);
            end
        end
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        n_vec++;
        if (obs !== 8'b0001_00_1_0) begin
            n_err++; $display("FAIL wdog_ack_wins: got %b want %b", obs, 8'b0001_00_1_0);
        end
`else
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if (obs !== 8'b0001_00_1_0) begin
                n_err++; $display("FAIL nowdog_hold[%0d]: got %b want %b", i, obs, 8'b0001_00_1_0);
            end
        end
`endif
        bus_if.req = 4'b0000;
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        n_vec++;
        if (obs !== 8'b0000_00_0_0) begin
            n_err++; $display("FAIL wdog_cleanup: got %b want %b", obs, 8'b0000_00_0_0);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
